keypad4x4_emulator: RTL



---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/scan_edge_detect.sv | 31 +++
 rtl/keypad4x4_emulator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the keypad scanner:
// FSM states, key-code field positions and idle line level.
package keypad_pkg;

  localparam int unsigned LINES   = 4;
  localparam int unsigned KEY_W   = 4;
  localparam int unsigned ROW_MSB = 3;
  localparam int unsigned ROW_LSB = 2;
  localparam int unsigned COL_MSB = 1;
  localparam int unsigned COL_LSB = 0;
  localparam int unsigned SEL_W   = COL_MSB - COL_LSB + 1;

  localparam logic [LINES-1:0] IDLE_LINES = {LINES{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BOUNCE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic [ROW_MSB-ROW_LSB:0] row;
    logic [COL_MSB-COL_LSB:0] col;
  } key_code_t;

  // Width of a counter able to hold the largest of three scan-pass budgets.
  function automatic int unsigned scan_cnt_width(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_edge_detect.sv
// Two-flop col synchroniser with a falling-edge detector on the selected column.
module scan_edge_detect
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LINES-1:0] col_i,
  input  logic [SEL_W-1:0] col_sel_i,
  output logic             scan_edge_c
);

  logic [LINES-1:0] sync1_q;
  logic [LINES-1:0] sync2_q;
  logic [LINES-1:0] prev_q;

  // prev_q keeps every column so a change of col_sel_i never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LINES;
      sync2_q <= IDLE_LINES;
      prev_q  <= IDLE_LINES;
    end else begin
      sync1_q <= col_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign scan_edge_c = prev_q[col_sel_i] & ~sync2_q[col_sel_i];

endmodule

// File: rtl/keypad4x4_emulator.sv
// Responder side of a 4x4 matrix keypad: closes the requested switch for a
// number of scan passes (with optional contact bounce), then releases it.
module keypad4x4_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_SCANS  = 2,
  parameter int unsigned HOLD_SCANS    = 8,
  parameter int unsigned RELEASE_SCANS = 4,
  parameter int unsigned TIMEOUT_CLKS  = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LINES-1:0] col,
  output logic [LINES-1:0] row,
  input  logic [KEY_W-1:0] key_code,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             key_active,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned CNT_W = scan_cnt_width(BOUNCE_SCANS, HOLD_SCANS, RELEASE_SCANS);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] BOUNCE_LAST  = CNT_W'(BOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_SCANS - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_SCANS - 1);
  localparam logic [WD_W-1:0]  WD_LAST      = WD_W'(TIMEOUT_CLKS - 1);

  localparam state_e FIRST_STATE = (BOUNCE_SCANS == 0) ? HOLD : BOUNCE;

  state_e           state_q;
  key_code_t        kc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WD_W-1:0]  wd_q;
  logic             key_active_q;
  logic             req_ready_q;
  logic             done_q;
  logic             timeout_q;
  logic             scan_edge_c;

  scan_edge_detect u_edge (
    .clk         (clk),
    .reset_n     (reset_n),
    .col_i       (col),
    .col_sel_i   (kc_q.col),
    .scan_edge_c (scan_edge_c)
  );

  // Press sequencer: counts scan edges of the key column per phase, with a
  // watchdog that aborts when the scanner stops driving that column.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      kc_q         <= '0;
      cnt_q        <= '0;
      wd_q         <= '0;
      key_active_q <= 1'b0;
      req_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            kc_q.row     <= key_code[ROW_MSB:ROW_LSB];
            kc_q.col     <= key_code[COL_MSB:COL_LSB];
            cnt_q        <= '0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            req_ready_q  <= 1'b0;
            key_active_q <= 1'b1;
            state_q      <= FIRST_STATE;
          end
        end
        default: begin
          if (scan_edge_c) begin
            wd_q  <= '0;
            cnt_q <= cnt_q + 1'b1;
            case (state_q)
              BOUNCE: begin
                if (cnt_q == BOUNCE_LAST) begin
                  state_q      <= HOLD;
                  cnt_q        <= '0;
                  key_active_q <= 1'b1;
                end else begin
                  key_active_q <= ~key_active_q;
                end
              end
              HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                  state_q      <= RELEASE;
                  cnt_q        <= '0;
                  key_active_q <= 1'b0;
                end
              end
              RELEASE: begin
                if (cnt_q == RELEASE_LAST) begin
                  state_q     <= IDLE;
                  cnt_q       <= '0;
                  done_q      <= 1'b1;
                  req_ready_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (wd_q == WD_LAST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wd_q         <= '0;
            key_active_q <= 1'b0;
            timeout_q    <= 1'b1;
            done_q       <= 1'b1;
            req_ready_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Switch model: zero-latency path from the raw column drive to the row.
  always_comb begin
    row = IDLE_LINES;
    if (key_active_q && !col[kc_q.col]) begin
      row[kc_q.row] = 1'b0;
    end
  end

  assign req_ready  = req_ready_q;
  assign key_active = key_active_q;
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule
